// File: rtl/u_interpolator_pkg.sv
// Shared Euler-engine definitions: FSM state encoding, sample width, default widths.
// Imported by the interpolator top and its lerp datapath.
package euler_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 64;
  localparam int FRAC_W_DEF = 16;
  localparam int SAMPLE_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Widen a sample by one bit so that U1-U0 cannot overflow.
  function automatic logic signed [SAMPLE_W:0] sext17(input logic [SAMPLE_W-1:0] s);
    return {s[SAMPLE_W-1], s};
  endfunction

endpackage

// File: rtl/u_interpolator_if.sv
// Control, RAM-port and status bundle of the input interpolator.
// The slave modport is the interpolator side; master is its controller/RAM side.
interface u_interpolator_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int FRAC_W        = 16
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] m_val;
  logic [FRAC_W-1:0]        t_frac;
  logic [ADDRESS_WIDTH-1:0] u0_base;
  logic [ADDRESS_WIDTH-1:0] u1_base;
  logic [ADDRESS_WIDTH-1:0] u_base;
  logic [ADDRESS_WIDTH-1:0] rd_add1;
  logic [ADDRESS_WIDTH-1:0] rd_add2;
  logic [DATA_WIDTH-1:0]    rd_data1;
  logic [DATA_WIDTH-1:0]    rd_data2;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_add;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, m_val, t_frac, u0_base, u1_base, u_base, rd_data1, rd_data2,
    output rd_add1, rd_add2, wr_en, wr_add, wr_data, busy, done
  );

  modport master (
    output start, m_val, t_frac, u0_base, u1_base, u_base, rd_data1, rd_data2,
    input  rd_add1, rd_add2, wr_en, wr_add, wr_data, busy, done
  );
endinterface

// File: rtl/u_interpolator_lerp.sv
// Combinational lerp r = U0 + (U1-U0)*T_FRAC, shift by FRAC_W with floor or round-half-up.
// Build option INTERP_ROUND_EN selects round-half-up; the result always lies in [U0,U1].
module interp_lerp
  import euler_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [SAMPLE_W-1:0] u0,
  input  logic [SAMPLE_W-1:0] u1,
  input  logic [FRAC_W-1:0]   t_frac,
  output logic [SAMPLE_W-1:0] r
);

  localparam int P_W = SAMPLE_W + 1 + FRAC_W;

  logic signed [SAMPLE_W:0] d;
  logic signed [P_W-1:0]    p;
  logic signed [P_W-1:0]    p_adj;
  logic signed [P_W-1:0]    q;
  logic        [SAMPLE_W:0] sum;
  logic                     unused_q_bits;

  always_comb begin
    d = sext17(u1) - sext17(u0);
    p = P_W'(d) * P_W'($signed({1'b0, t_frac}));
`ifdef INTERP_ROUND_EN
    p_adj = p + (P_W'(1) <<< (FRAC_W - 1));
`else
    p_adj = p;
`endif
    q   = p_adj >>> FRAC_W;
    // Result fits 16 bits, so the low 17 bits of the step are sufficient.
    sum = sext17(u0) + q[SAMPLE_W:0];
    r   = sum[SAMPLE_W-1:0];
  end

  assign unused_q_bits = ^{q[P_W-1:SAMPLE_W+1], sum[SAMPLE_W]};

endmodule

// File: rtl/u_interpolator.sv
// Builds U(t) = U0 + (U1-U0)*T_FRAC element by element into the U region of the shared RAM.
// 3 cycles per element, DONE level 3*m+1 cycles after START; rounding via INTERP_ROUND_EN.
module u_interpolator
  import euler_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int FRAC_W        = FRAC_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  u_interpolator_if.slave bus
);

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDRESS_WIDTH-1:0] m_q;
  logic [ADDRESS_WIDTH-1:0] u0_base_q;
  logic [ADDRESS_WIDTH-1:0] u1_base_q;
  logic [ADDRESS_WIDTH-1:0] u_base_q;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [FRAC_W-1:0]        t_q;
  logic [SAMPLE_W-1:0]      u0_q;
  logic [SAMPLE_W-1:0]      u1_q;
  logic [SAMPLE_W-1:0]      r;
  logic                     done_q;
  logic                     accept;
  logic                     last;
  logic                     unused_rd_bits;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (idx == m_q - ADDRESS_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.m_val != '0) ? ISSUE : FINISH;
      ISSUE:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_add1 = '0;
    bus.rd_add2 = '0;
    bus.wr_en   = 1'b0;
    bus.wr_add  = '0;
    bus.wr_data = '0;
    bus.busy    = (state != IDLE);
    bus.done    = done_q;
    case (state)
      ISSUE: begin
        bus.rd_add1 = u0_base_q + idx;
        bus.rd_add2 = u1_base_q + idx;
      end
      WRITE: begin
        bus.wr_en   = 1'b1;
        bus.wr_add  = u_base_q + idx;
        bus.wr_data = {{(DATA_WIDTH-SAMPLE_W){r[SAMPLE_W-1]}}, r};
      end
      default: ;
    endcase
  end

  // Operands are captured only on an accepted START; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      t_q       <= '0;
      u0_base_q <= '0;
      u1_base_q <= '0;
      u_base_q  <= '0;
      idx       <= '0;
      u0_q      <= '0;
      u1_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        m_q       <= bus.m_val;
        t_q       <= bus.t_frac;
        u0_base_q <= bus.u0_base;
        u1_base_q <= bus.u1_base;
        u_base_q  <= bus.u_base;
        idx       <= '0;
        done_q    <= 1'b0;
      end else if (state == FINISH) begin
        done_q    <= 1'b1;
      end
      if (state == READ) begin
        u0_q <= bus.rd_data1[SAMPLE_W-1:0];
        u1_q <= bus.rd_data2[SAMPLE_W-1:0];
      end
      if (state == WRITE) idx <= idx + ADDRESS_WIDTH'(1);
    end
  end

  interp_lerp #(.FRAC_W(FRAC_W)) u_lerp (
    .u0     (u0_q),
    .u1     (u1_q),
    .t_frac (t_q),
    .r      (r)
  );

  assign unused_rd_bits = ^{bus.rd_data1[DATA_WIDTH-1:SAMPLE_W], bus.rd_data2[DATA_WIDTH-1:SAMPLE_W]};

endmodule
